// File: rtl/instr_fetch_unit.sv
// Instruction fetch unit: latches the committed PC, reads the word over a
// ready-handshake bus and loads the instruction register with PC+1 alongside.
module instr_fetch_unit #(
    parameter int ADDR_W  = 16,
    parameter int DATA_W  = 16,
    parameter int TIMEOUT = 15
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              fetch_start,
    input  logic [ADDR_W-1:0] pc_in,
    output logic [ADDR_W-1:0] mem_addr,
    output logic              mem_rd,
    input  logic              mem_ready,
    input  logic [DATA_W-1:0] mem_rdata,
    output logic [DATA_W-1:0] ir_out,
    output logic [ADDR_W-1:0] npc_out,
    output logic              fetch_done,
    output logic              busy,
    output logic              fetch_err,
    output logic [15:0]       fetch_count
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        REQ  = 2'd1,
        DONE = 2'd2,
        ERR  = 2'd3
    } state_t;

    localparam logic [7:0] WAIT_MAX = 8'(TIMEOUT);

    state_t            state_q, state_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic [DATA_W-1:0] ir_q, ir_d;
    logic [ADDR_W-1:0] npc_q, npc_d;
    logic              err_q, err_d;
    logic [15:0]       cnt_q, cnt_d;
    logic [7:0]        wait_q, wait_d;
    logic              rd_q, rd_d;
    logic              busy_q, busy_d;
    logic              done_q, done_d;

    always_comb begin
        state_d = state_q;
        addr_d  = addr_q;
        ir_d    = ir_q;
        npc_d   = npc_q;
        err_d   = err_q;
        cnt_d   = cnt_q;
        wait_d  = wait_q;
        case (state_q)
            REQ: begin
                if (mem_ready) begin
                    ir_d    = mem_rdata;
                    npc_d   = addr_q + ADDR_W'(1);
                    cnt_d   = cnt_q + 16'd1;
                    state_d = DONE;
                end else if (wait_q == WAIT_MAX) begin
                    err_d   = 1'b1;
                    state_d = ERR;
                end else begin
                    wait_d = wait_q + 8'd1;
                end
            end
            default: begin
                // IDLE, DONE and ERR all accept a new request the same way
                if (fetch_start) begin
                    addr_d  = pc_in;
                    wait_d  = 8'd0;
                    err_d   = 1'b0;
                    state_d = REQ;
                end else if (state_q != ERR) begin
                    state_d = IDLE;
                end
            end
        endcase
        rd_d   = (state_d == REQ);
        busy_d = (state_d == REQ);
        done_d = (state_d == DONE);
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q <= IDLE;
            addr_q  <= '0;
            ir_q    <= '0;
            npc_q   <= '0;
            err_q   <= 1'b0;
            cnt_q   <= '0;
            wait_q  <= '0;
            rd_q    <= 1'b0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            addr_q  <= addr_d;
            ir_q    <= ir_d;
            npc_q   <= npc_d;
            err_q   <= err_d;
            cnt_q   <= cnt_d;
            wait_q  <= wait_d;
            rd_q    <= rd_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
        end
    end

    assign mem_addr    = addr_q;
    assign mem_rd      = rd_q;
    assign busy        = busy_q;
    assign ir_out      = ir_q;
    assign npc_out     = npc_q;
    assign fetch_done  = done_q;
    assign fetch_err   = err_q;
    assign fetch_count = cnt_q;

endmodule

// File: tb/tb_instr_fetch_unit.sv
// Bench for instr_fetch_unit: directed scenarios plus random traffic,
// all compared cycle by cycle against a transaction-level model.
module tb_instr_fetch_unit;

    localparam int TMO = 15;

    logic        clk = 1'b0;
    logic        reset;
    logic        fetch_start;
    logic [15:0] pc_in;
    logic [15:0] mem_addr;
    logic        mem_rd;
    logic        mem_ready;
    logic [15:0] mem_rdata;
    logic [15:0] ir_out;
    logic [15:0] npc_out;
    logic        fetch_done;
    logic        busy;
    logic        fetch_err;
    logic [15:0] fetch_count;

    int checks   = 0;
    int failures = 0;

    // model: an outstanding request and how long it has waited
    bit          m_active;
    int          m_waited;
    logic [15:0] m_addr;
    logic [15:0] m_ir;
    logic [15:0] m_npc;
    bit          m_done;
    bit          m_err;
    int          m_count;

    instr_fetch_unit #(.ADDR_W(16), .DATA_W(16), .TIMEOUT(TMO)) dut (
        .clk         (clk),
        .reset       (reset),
        .fetch_start (fetch_start),
        .pc_in       (pc_in),
        .mem_addr    (mem_addr),
        .mem_rd      (mem_rd),
        .mem_ready   (mem_ready),
        .mem_rdata   (mem_rdata),
        .ir_out      (ir_out),
        .npc_out     (npc_out),
        .fetch_done  (fetch_done),
        .busy        (busy),
        .fetch_err   (fetch_err),
        .fetch_count (fetch_count)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act,
                       input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp,
                     $time);
        end
    endtask

    task automatic model_reset();
        m_active = 0;
        m_waited = 0;
        m_addr   = 0;
        m_ir     = 0;
        m_npc    = 0;
        m_done   = 0;
        m_err    = 0;
        m_count  = 0;
    endtask

    task automatic model_step(input bit st, input bit rdy,
                              input logic [15:0] rd, input logic [15:0] pc);
        if (m_active) begin
            if (rdy) begin
                m_ir     = rd;
                m_npc    = 16'((int'(m_addr) + 1) % 65536);
                m_count  = (m_count + 1) % 65536;
                m_active = 0;
                m_done   = 1;
            end else if (m_waited == TMO) begin
                m_err    = 1;
                m_active = 0;
            end else begin
                m_waited++;
            end
        end else begin
            m_done = 0;
            if (st) begin
                m_addr   = pc;
                m_waited = 0;
                m_err    = 0;
                m_active = 1;
            end
        end
    endtask

    task automatic compare_all();
        chk("mem_rd", 32'(mem_rd), 32'(m_active));
        chk("busy", 32'(busy), 32'(m_active));
        chk("mem_addr", 32'(mem_addr), 32'(m_addr));
        chk("ir_out", 32'(ir_out), 32'(m_ir));
        chk("npc_out", 32'(npc_out), 32'(m_npc));
        chk("fetch_done", 32'(fetch_done), 32'(m_done));
        chk("fetch_err", 32'(fetch_err), 32'(m_err));
        chk("fetch_count", 32'(fetch_count), 32'(m_count));
    endtask

    // called at a negedge: drive inputs, advance model, compare at next negedge
    task automatic cyc(input bit st, input bit rdy, input logic [15:0] rd,
                       input logic [15:0] pc);
        fetch_start = st;
        mem_ready   = rdy;
        mem_rdata   = rd;
        pc_in       = pc;
        model_step(st, rdy, rd, pc);
        @(negedge clk);
        compare_all();
    endtask

    initial begin
        reset       = 1'b0;
        fetch_start = 1'b0;
        pc_in       = '0;
        mem_ready   = 1'b0;
        mem_rdata   = '0;
        model_reset();
        repeat (2) @(negedge clk);
        compare_all();
        chk("reset_rd", 32'(mem_rd), 32'd0);
        reset = 1'b1;

        // single fetch, ready in first REQ cycle
        cyc(1, 0, 16'h0, 16'h0010);
        chk("t1_rd", 32'(mem_rd), 32'd1);
        chk("t1_addr", 32'(mem_addr), 32'h0010);
        cyc(0, 1, 16'hA5C3, 16'h0);
        chk("t1_ir", 32'(ir_out), 32'hA5C3);
        chk("t1_npc", 32'(npc_out), 32'h0011);
        chk("t1_done", 32'(fetch_done), 32'd1);
        chk("t1_cnt", 32'(fetch_count), 32'd1);
        cyc(0, 0, 16'h0, 16'h0);
        chk("t1_done_pulse", 32'(fetch_done), 32'd0);

        // delayed ready, pc_in moving underneath
        cyc(1, 0, 16'h0, 16'h1234);
        for (int i = 0; i < 5; i++) begin
            cyc(0, 0, 16'($urandom), 16'($urandom));
            chk("t2_rd_held", 32'(mem_rd), 32'd1);
            chk("t2_addr", 32'(mem_addr), 32'h1234);
            chk("t2_ir_old", 32'(ir_out), 32'hA5C3);
        end
        cyc(0, 1, 16'hBEEF, 16'h5555);
        chk("t2_ir", 32'(ir_out), 32'hBEEF);
        chk("t2_npc", 32'(npc_out), 32'h1235);

        // timeout after TMO+1 REQ cycles without ready
        cyc(1, 0, 16'h0, 16'h0400);
        for (int i = 0; i < TMO + 1; i++) cyc(0, 0, 16'h0, 16'h0);
        chk("t3_err", 32'(fetch_err), 32'd1);
        chk("t3_rd", 32'(mem_rd), 32'd0);
        chk("t3_ir_kept", 32'(ir_out), 32'hBEEF);
        cyc(0, 1, 16'h7777, 16'h0);
        chk("t3_late_ready", 32'(ir_out), 32'hBEEF);
        cyc(1, 0, 16'h0, 16'h0500);
        chk("t3_err_clr", 32'(fetch_err), 32'd0);
        cyc(0, 1, 16'h1111, 16'h0);
        chk("t3_ir_new", 32'(ir_out), 32'h1111);

        // address wrap
        cyc(1, 0, 16'h0, 16'hFFFF);
        cyc(0, 1, 16'h2468, 16'h0);
        chk("t4_npc_wrap", 32'(npc_out), 32'h0000);

        // start in REQ ignored, start in DONE goes straight to REQ
        cyc(1, 0, 16'h0, 16'h0100);
        cyc(1, 0, 16'h0, 16'h0200);
        chk("t5_req_ign", 32'(mem_addr), 32'h0100);
        cyc(1, 1, 16'h3333, 16'h0300);
        chk("t5_cnt", 32'(fetch_count), 32'd5);
        cyc(1, 0, 16'h0, 16'h2222);
        chk("t5_b2b_rd", 32'(mem_rd), 32'd1);
        chk("t5_b2b_addr", 32'(mem_addr), 32'h2222);
        cyc(0, 1, 16'h4444, 16'h0);

        // random traffic
        for (int i = 0; i < 3000; i++)
            cyc(($urandom_range(0, 3) == 0), ($urandom_range(0, 9) < 3),
                16'($urandom), 16'($urandom));
        for (int i = 0; i < 40; i++)
            cyc(($urandom_range(0, 19) == 0), 1'b0, 16'($urandom),
                16'($urandom));

        // asynchronous reset in the middle of REQ
        cyc(1, 0, 16'h0, 16'h0ABC);
        cyc(0, 0, 16'h0, 16'h0);
        chk("t6_pre_rd", 32'(mem_rd), 32'd1);
        #2 reset = 1'b0;
        #1;
        chk("t6_rd", 32'(mem_rd), 32'd0);
        chk("t6_busy", 32'(busy), 32'd0);
        chk("t6_addr", 32'(mem_addr), 32'd0);
        chk("t6_ir", 32'(ir_out), 32'd0);
        chk("t6_cnt", 32'(fetch_count), 32'd0);
        model_reset();
        @(negedge clk);
        reset = 1'b1;
        cyc(0, 1, 16'h9999, 16'h0);
        chk("t6_idle", 32'(busy), 32'd0);
        cyc(1, 0, 16'h0, 16'h0042);
        cyc(0, 1, 16'h5A5A, 16'h0);
        chk("t6_after_ir", 32'(ir_out), 32'h5A5A);
        chk("t6_after_cnt", 32'(fetch_count), 32'd1);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
